// File: rtl/shift_unload.sv
// shift_unload: parallel-in, serial-out word unloader.
// Captures eight WIDTH-bit words a..h on an accepted load and presents them on
// dout one per valid/ready transfer, h first and a last. A load accepted during
// the final transfer of a burst starts the next burst with no bubble cycle.
// Optional feature: define SHIFT_UNLOAD_LAST_EN to add the 'last' output,
// which is high only while word a is presented.
module shift_unload #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             load_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [3:0]       count
`ifdef SHIFT_UNLOAD_LAST_EN
  ,
  output logic             last
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state, state_next;

  // bank[0] holds a, bank[7] holds h; the word on dout is always bank[count-1].
  logic [WIDTH-1:0] bank [8];

  logic       transfer;
  logic       load_acc;
  logic [2:0] next_idx;

  assign dout_valid = (state == SEND);
  assign transfer   = dout_valid & dout_ready;
  assign load_ready = (state == IDLE) | ((count == 4'd1) & dout_ready);
  assign load_acc   = load & load_ready;
  // Index of the word that follows dout; only consulted while count > 1.
  assign next_idx   = 3'(count - 4'd2);

`ifdef SHIFT_UNLOAD_LAST_EN
  assign last = dout_valid & (count == 4'd1);
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks evaluate.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: enter SEND on a load, leave it only after the final
  // transfer when no follow-on load is accepted in the same cycle.
  always_comb begin
    // NOTE: defaulting the output first keeps every path assigned, so no
    // latch is inferred when a branch below does not mention it.
    state_next = state;
    unique case (state)
      IDLE: if (load_acc) state_next = SEND;
      SEND: if (transfer && count == 4'd1 && !load_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the bank on an accepted load, step through it on each
  // transfer. dout keeps word a after the burst drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the bank is only eight registers and is cleared on reset so no
      // stale word from an aborted burst can ever reach dout.
      for (int i = 0; i < 8; i++) bank[i] <= '0;
      dout  <= '0;
      count <= 4'd0;
    end else if (load_acc) begin
      bank[0] <= a;
      bank[1] <= b;
      bank[2] <= c;
      bank[3] <= d;
      bank[4] <= e;
      bank[5] <= f;
      bank[6] <= g;
      bank[7] <= h;
      dout    <= h;
      count   <= 4'd8;
    end else if (transfer) begin
      count <= count - 4'd1;
      if (count > 4'd1) dout <= bank[next_idx];
    end
  end

endmodule

// File: tb/tb_shift_unload.sv
// Self-checking bench for shift_unload. A queue-based model holds the words
// still to be sent; every cycle the DUT outputs are compared against it.
// Define SHIFT_UNLOAD_LAST_EN to also exercise the 'last' output.
module tb_shift_unload;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, load, dout_ready;
  logic         load_ready, dout_valid;
  logic [W-1:0] dout;
  logic [3:0]   count;
  logic [W-1:0] words [8];   // words[0]=a .. words[7]=h
`ifdef SHIFT_UNLOAD_LAST_EN
  logic         last;
`endif

  always #5 clk = ~clk;

  shift_unload #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_ready (load_ready),
    .a          (words[0]),
    .b          (words[1]),
    .c          (words[2]),
    .d          (words[3]),
    .e          (words[4]),
    .f          (words[5]),
    .g          (words[6]),
    .h          (words[7]),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count)
`ifdef SHIFT_UNLOAD_LAST_EN
    ,
    .last       (last)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of words still to send (front = dout).
  logic [W-1:0] q [$];
  logic [W-1:0] last_word = '0;

  // Downstream 8-tap shift chain clocked on each transfer.
  logic [W-1:0] taps [8];
  int           last_hits = 0;
  logic [W-1:0] last_seen = '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) taps[i] <= '0;
    end else if (dout_valid && dout_ready) begin
      taps[0] <= dout;
      for (int i = 1; i < 8; i++) taps[i] <= taps[i-1];
    end
  end

`ifdef SHIFT_UNLOAD_LAST_EN
  always @(posedge clk) begin
    if (!reset && last && dout_valid && dout_ready) begin
      last_hits = last_hits + 1;
      last_seen = dout;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_load_ready(input logic rdy);
    return (q.size() == 0) || (q.size() == 1 && rdy);
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, advance the model.
  task automatic cycle(input logic rst, input logic ld, input logic rdy);
    logic acc, xfer;
    reset = rst; load = ld; dout_ready = rdy;
    @(negedge clk);
    check("dout_valid", 32'(dout_valid), 32'(q.size() > 0));
    check("count",      32'(count),      32'(q.size()));
    check("dout",       32'(dout),       32'(q.size() > 0 ? q[0] : last_word));
    check("load_ready", 32'(load_ready), 32'(model_load_ready(rdy)));
`ifdef SHIFT_UNLOAD_LAST_EN
    check("last",       32'(last),       32'(q.size() == 1));
`endif
    acc  = ld && model_load_ready(rdy);
    xfer = (q.size() > 0) && rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_word = '0;
    end else begin
      if (xfer) last_word = q.pop_front();
      if (acc) begin
        q.delete();
        for (int i = 7; i >= 0; i--) q.push_back(words[i]);
      end
    end
    #1;
  endtask

  task automatic set_seq(input logic [W-1:0] base);
    for (int i = 0; i < 8; i++) words[i] = base + W'(i);
  endtask

  task automatic set_rand();
    for (int i = 0; i < 8; i++) words[i] = W'($urandom);
  endtask

  logic [W-1:0] snap [8];
  int           valid_cycles;

  initial begin
    reset = 1'b1; load = 1'b0; dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = '1;
    @(posedge clk); #1;

    // 1: reset overrides a simultaneous load of all-ones words.
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("rst_dout_zero", 32'(dout), 32'h0);

    // 2: full burst with dout_ready held high.
    set_seq(16'h0001);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("burst_dout", 32'(dout), 32'(8 - i));
      cycle(1'b0, 1'b0, 1'b1);
    end
    check("drain_valid", 32'(dout_valid), 32'h0);
    check("drain_dout",  32'(dout), 32'h0001);

    // 3: stall for three cycles after two transfers.
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("stall_dout",  32'(dout),  32'h0006);
      check("stall_count", 32'(count), 32'h6);
      cycle(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
    check("stall_done", 32'(dout_valid), 32'h0);

    // 4: second load during final transfer, sixteen contiguous valid cycles.
    cycle(1'b0, 1'b1, 1'b1);
    set_seq(16'h0011);
    valid_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (dout_valid) valid_cycles++;
      cycle(1'b0, (i == 7), 1'b1);
    end
    check("b2b_valid_cycles", 32'(valid_cycles), 32'd16);
    check("b2b_end_dout", 32'(dout), 32'h0011);

    // 5: mid-burst load ignored, then reset after three transfers.
    set_seq(16'h0001);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) words[i] = 16'hAAAA;
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("ign_dout", 32'(dout), 32'h0005);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check("rst_mid_ready", 32'(load_ready), 32'h1);

    // 6: loopback into shift chain with random stalls.
    set_rand();
    for (int i = 0; i < 8; i++) snap[i] = words[i];
    last_hits = 0;
    cycle(1'b0, 1'b1, 1'b1);
    set_rand();
    for (int n = 0; n < 64 && q.size() > 0; n++)
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
    check("loop_drained", 32'(q.size()), 32'h0);
    for (int i = 0; i < 8; i++) check("loop_tap", 32'(taps[i]), 32'(snap[i]));
`ifdef SHIFT_UNLOAD_LAST_EN
    check("last_hits", 32'(last_hits), 32'd1);
    check("last_word", 32'(last_seen), 32'(snap[0]));
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      set_rand();
      cycle(1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
